calc_ctrl: RTL and testbench



---
 rtl/calc_ctrl_if.sv | 73 +++++++
 rtl/calc_ctrl.sv | 174 +++++++++++++++++
 tb/tb_calc_ctrl.sv | 309 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/calc_ctrl_if.sv
// Shared calculator types plus the button/ALU/display bundle that connects
// calc_ctrl to the button decoder, the BCD ALU and the display driver.
package calc_pkg;
   localparam int NumDigits = 8;
   localparam int ExpW      = 4;

   typedef struct packed {
      logic                       sign;
      logic                       error;
      logic [ExpW-1:0]            exponent;
      logic [NumDigits-1:0][3:0]  significand;
   } num_t;

   typedef enum logic [2:0] {
      OP_NONE, OP_ADD, OP_SUB, OP_MUL, OP_DIV, OP_PERCENT, OP_SQRT
   } op_t;

   typedef enum logic [4:0] {
      B_NONE, B_0, B_1, B_2, B_3, B_4, B_5, B_6, B_7, B_8, B_9,
      B_DOT, B_ADD, B_SUB, B_MUL, B_DIV, B_PERCENT, B_SQRT, B_EQ, B_CLEAR,
      B_MC, B_MR, B_MADD, B_MSUB, B_UNKNOWN
   } active_button_t;

   function automatic logic isNumberButton(input active_button_t b);
      return (b >= B_0) && (b <= B_9);
   endfunction

   function automatic logic [3:0] button2bcd(input active_button_t b);
      return 4'(5'(b) - 5'(B_0));
   endfunction

   function automatic op_t button2op(input active_button_t b);
      case (b)
         B_ADD:     return OP_ADD;
         B_SUB:     return OP_SUB;
         B_MUL:     return OP_MUL;
         B_DIV:     return OP_DIV;
         B_PERCENT: return OP_PERCENT;
         B_SQRT:    return OP_SQRT;
         default:   return OP_NONE;
      endcase
   endfunction

   function automatic logic [NumDigits-1:0][3:0] leftshift_significand(
      input logic [NumDigits-1:0][3:0] sig, input logic [3:0] digit);
      return {sig[NumDigits-2:0], digit};
   endfunction
endpackage

interface calc_ctrl_if;
   import calc_pkg::*;

   logic           button_valid_i;
   active_button_t button_i;
   logic           alu_req_o;
   op_t            alu_op_o;
   num_t           alu_a_o;
   num_t           alu_b_o;
   logic           alu_ack_i;
   num_t           alu_result_i;
   num_t           display_o;
   logic           busy_o;

   modport slave (
      input  button_valid_i, button_i, alu_ack_i, alu_result_i,
      output alu_req_o, alu_op_o, alu_a_o, alu_b_o, display_o, busy_o
   );

   modport master (
      output button_valid_i, button_i, alu_ack_i, alu_result_i,
      input  alu_req_o, alu_op_o, alu_a_o, alu_b_o, display_o, busy_o
   );
endinterface

// File: rtl/calc_ctrl.sv
// Keypad-to-ALU sequencer: builds BCD operands from key presses, runs the
// pending operator through the ALU req/ack handshake and drives the display.
//
// state     | meaning
// S_ENTRY_A | building left operand in entry
// S_OP_WAIT | operator chosen, display shows acc, no B digit yet
// S_ENTRY_B | building right operand in entry
// S_EXEC    | ALU request outstanding, non-clear keys dropped
// S_RESULT  | showing result held in acc
// S_ERROR   | showing error result, only clear exits
module calc_ctrl
   import calc_pkg::*;
#(
   parameter int NumDigits = calc_pkg::NumDigits
) (
   input logic        clk_i,
   input logic        rst_ni,
   calc_ctrl_if.slave bus
);
   localparam int CntW = $clog2(NumDigits + 1);

   typedef enum logic [2:0] {
      S_ENTRY_A, S_OP_WAIT, S_ENTRY_B, S_EXEC, S_RESULT, S_ERROR
   } state_t;

   // Every reset value is zero, so a clear is simply loading '0 into this.
   typedef struct packed {
      state_t          state;
      num_t            entry;
      logic [CntW-1:0] digit_cnt;
      logic            dot_seen;
      num_t            acc;
      op_t             pend_op;
      op_t             next_op;
      logic            clear_pend;
      logic            alu_req;
      op_t             alu_op;
      num_t            alu_a;
      num_t            alu_b;
      num_t            display;
      logic            busy;
   } ctl_t;

   ctl_t            r_ctl;
   num_t            w_base;
   num_t            w_next;
   logic [CntW-1:0] w_base_cnt;
   logic [CntW-1:0] w_next_cnt;
   logic            w_base_dot;
   logic            w_next_dot;
   logic [3:0]      w_digit;
   op_t             w_op;
   logic            w_is_digit;
   logic            w_is_dot;
   logic            w_is_op;
   logic            w_is_eq;
   logic            w_is_clear;
   logic            w_ack;
   logic            w_fresh;
   logic            w_key;
   logic            w_do_clear;

   assign w_digit    = button2bcd(bus.button_i);
   assign w_op       = button2op(bus.button_i);
   assign w_is_digit = bus.button_valid_i && isNumberButton(bus.button_i);
   assign w_is_dot   = bus.button_valid_i && (bus.button_i == B_DOT);
   assign w_is_op    = bus.button_valid_i && (w_op inside {OP_ADD, OP_SUB, OP_MUL, OP_DIV});
   assign w_is_eq    = bus.button_valid_i && (bus.button_i == B_EQ);
   assign w_is_clear = bus.button_valid_i && (bus.button_i == B_CLEAR);
   assign w_ack      = r_ctl.alu_req && bus.alu_ack_i;

   // After an operator or a result, the first key starts a fresh operand.
   assign w_fresh = r_ctl.state inside {S_OP_WAIT, S_RESULT};
   assign w_key   = (w_is_digit || w_is_dot) && !(r_ctl.state inside {S_EXEC, S_ERROR});

   assign w_do_clear = (w_is_clear && r_ctl.state != S_EXEC) ||
                       (r_ctl.state == S_EXEC && w_ack && (w_is_clear || r_ctl.clear_pend));

   always_comb begin
      w_base     = w_fresh ? num_t'('0) : r_ctl.entry;
      w_base_cnt = w_fresh ? '0 : r_ctl.digit_cnt;
      w_base_dot = w_fresh ? 1'b0 : r_ctl.dot_seen;
      w_next     = w_base;
      w_next_cnt = w_base_cnt;
      w_next_dot = w_base_dot;
      if (w_is_digit && (w_base_cnt < CntW'(NumDigits)) &&
          (!w_base_dot || (w_base.exponent < ExpW'(NumDigits - 1)))) begin
         w_next.significand = leftshift_significand(w_base.significand, w_digit);
         if (w_digit != 4'd0 || w_base_cnt != '0 || w_base_dot) begin
            w_next_cnt = w_base_cnt + CntW'(1);
         end
         if (w_base_dot) begin
            w_next.exponent = w_base.exponent + ExpW'(1);
         end
      end else if (w_is_dot) begin
         w_next_dot = 1'b1;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_ctl <= '0;
      end else if (w_do_clear) begin
         r_ctl <= '0;
      end else begin
         if (w_key) begin
            r_ctl.entry     <= w_next;
            r_ctl.digit_cnt <= w_next_cnt;
            r_ctl.dot_seen  <= w_next_dot;
            r_ctl.display   <= w_next;
         end
         case (r_ctl.state)
            S_ENTRY_A: begin
               if (w_is_op) begin
                  r_ctl.acc     <= r_ctl.entry;
                  r_ctl.pend_op <= w_op;
                  r_ctl.display <= r_ctl.entry;
                  r_ctl.state   <= S_OP_WAIT;
               end
            end
            S_OP_WAIT: begin
               if (w_is_op) r_ctl.pend_op <= w_op;
               else if (w_key) r_ctl.state <= S_ENTRY_B;
            end
            S_ENTRY_B: begin
               if (w_is_eq || w_is_op) begin
                  r_ctl.alu_req <= 1'b1;
                  r_ctl.busy    <= 1'b1;
                  r_ctl.alu_op  <= r_ctl.pend_op;
                  r_ctl.alu_a   <= r_ctl.acc;
                  r_ctl.alu_b   <= r_ctl.entry;
                  r_ctl.next_op <= w_is_op ? w_op : OP_NONE;
                  r_ctl.state   <= S_EXEC;
               end
            end
            S_EXEC: begin
               if (w_is_clear) r_ctl.clear_pend <= 1'b1;
               if (w_ack) begin
                  r_ctl.alu_req <= 1'b0;
                  r_ctl.busy    <= 1'b0;
                  r_ctl.display <= bus.alu_result_i;
                  if (bus.alu_result_i.error) begin
                     r_ctl.state <= S_ERROR;
                  end else begin
                     r_ctl.acc <= bus.alu_result_i;
                     if (r_ctl.next_op == OP_NONE) begin
                        r_ctl.state <= S_RESULT;
                     end else begin
                        r_ctl.pend_op <= r_ctl.next_op;
                        r_ctl.state   <= S_OP_WAIT;
                     end
                  end
               end
            end
            S_RESULT: begin
               if (w_is_op) begin
                  r_ctl.pend_op <= w_op;
                  r_ctl.state   <= S_OP_WAIT;
               end else if (w_key) begin
                  r_ctl.state <= S_ENTRY_A;
               end
            end
            default: ;
         endcase
      end
   end

   assign bus.alu_req_o = r_ctl.alu_req;
   assign bus.alu_op_o  = r_ctl.alu_op;
   assign bus.alu_a_o   = r_ctl.alu_a;
   assign bus.alu_b_o   = r_ctl.alu_b;
   assign bus.display_o = r_ctl.display;
   assign bus.busy_o    = r_ctl.busy;
endmodule

// File: tb/tb_calc_ctrl.sv
// Self-checking bench for calc_ctrl: table-driven digit-entry vectors plus
// hand-written ALU handshake sequences checked against a request scoreboard.
module tb_calc_ctrl;
   import calc_pkg::*;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   calc_ctrl_if bus();

   calc_ctrl #(.NumDigits(8)) dut (
      .clk_i  (clk),
      .rst_ni (rst_n),
      .bus    (bus)
   );

   typedef struct {
      active_button_t btn;
      logic [31:0]    sig;
      logic [3:0]     expo;
   } vec_t;

   typedef struct {
      op_t  op;
      num_t a;
      num_t b;
   } req_t;

   vec_t vecs[$];
   req_t exp_q[$];
   int   n_vec = 0;
   int   n_bad = 0;

   function automatic num_t mk(input logic [31:0] sig, input logic [3:0] e = 4'd0,
                               input logic err = 1'b0);
      num_t n = '0;
      n.significand = sig;
      n.exponent    = e;
      n.error       = err;
      return n;
   endfunction

   function automatic active_button_t dig(input int k);
      return active_button_t'(5'(int'(B_0) + k));
   endfunction

   task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
      n_vec++;
      if (got !== want) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", name, got, want);
      end
   endtask

   task automatic add_vec(input active_button_t b, input logic [31:0] sig, input logic [3:0] e);
      vec_t v;
      v.btn  = b;
      v.sig  = sig;
      v.expo = e;
      vecs.push_back(v);
   endtask

   task automatic press(input active_button_t b);
      @(negedge clk);
      bus.button_valid_i = 1'b1;
      bus.button_i       = b;
      @(negedge clk);
      bus.button_valid_i = 1'b0;
      bus.button_i       = B_NONE;
   endtask

   task automatic expect_req(input op_t op, input num_t a, input num_t b);
      req_t r;
      r.op = op;
      r.a  = a;
      r.b  = b;
      exp_q.push_back(r);
   endtask

   // Acts as the ALU: waits for the request, compares it with the scoreboard,
   // holds off for 'delay' cycles, then acks (optionally together with clear).
   task automatic serve(input string name, input int delay, input num_t result,
                        input logic clear_same, input num_t want_disp);
      req_t e;
      int   waited = 0;
      while (!bus.alu_req_o && waited < 20) begin
         @(negedge clk);
         waited++;
      end
      check({name, "_req_rise"}, 64'(bus.alu_req_o), 64'd1);
      if (exp_q.size() == 0) begin
         n_vec++;
         n_bad++;
         $display("FAIL %s_sb: got request expected none queued", name);
         return;
      end
      e = exp_q.pop_front();
      for (int i = 0; i <= delay; i++) begin
         check({name, "_req_hold"}, 64'(bus.alu_req_o), 64'd1);
         check({name, "_busy"},     64'(bus.busy_o), 64'd1);
         check({name, "_op"},       64'(bus.alu_op_o), 64'(e.op));
         check({name, "_a"},        64'(bus.alu_a_o), 64'(e.a));
         check({name, "_b"},        64'(bus.alu_b_o), 64'(e.b));
         if (i < delay) @(negedge clk);
      end
      bus.alu_ack_i    = 1'b1;
      bus.alu_result_i = result;
      if (clear_same) begin
         bus.button_valid_i = 1'b1;
         bus.button_i       = B_CLEAR;
      end
      @(negedge clk);
      bus.alu_ack_i      = 1'b0;
      bus.alu_result_i   = '0;
      bus.button_valid_i = 1'b0;
      bus.button_i       = B_NONE;
      check({name, "_req_fall"}, 64'(bus.alu_req_o), 64'd0);
      check({name, "_busy_fall"}, 64'(bus.busy_o), 64'd0);
      check({name, "_disp"}, 64'(bus.display_o), 64'(want_disp));
   endtask

   task automatic check_disp(input string name, input num_t want);
      check(name, 64'(bus.display_o), 64'(want));
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      logic [31:0] s;
      req_t        e;

      bus.button_valid_i = 1'b0;
      bus.button_i       = B_NONE;
      bus.alu_ack_i      = 1'b0;
      bus.alu_result_i   = '0;

      // Vector table: one key per record, display expected afterwards.
      add_vec(B_CLEAR, 32'h0, 4'd0);
      add_vec(B_1, 32'h1, 4'd0);
      add_vec(B_2, 32'h12, 4'd0);
      add_vec(B_DOT, 32'h12, 4'd0);
      add_vec(B_5, 32'h125, 4'd1);
      add_vec(B_DOT, 32'h125, 4'd1);
      add_vec(B_MR, 32'h125, 4'd1);
      add_vec(B_PERCENT, 32'h125, 4'd1);
      add_vec(B_UNKNOWN, 32'h125, 4'd1);
      add_vec(B_EQ, 32'h125, 4'd1);
      add_vec(B_CLEAR, 32'h0, 4'd0);
      add_vec(B_0, 32'h0, 4'd0);
      add_vec(B_0, 32'h0, 4'd0);
      add_vec(B_7, 32'h7, 4'd0);
      s = 32'h7;
      for (int k = 1; k <= 7; k++) begin
         s = (s << 4) | 32'(k);
         add_vec(dig(k), s, 4'd0);
      end
      add_vec(B_8, 32'h71234567, 4'd0);
      add_vec(B_CLEAR, 32'h0, 4'd0);
      s = 32'h0;
      for (int k = 1; k <= 8; k++) begin
         s = (s << 4) | 32'(k);
         add_vec(dig(k), s, 4'd0);
      end
      add_vec(B_9, 32'h12345678, 4'd0);
      add_vec(B_CLEAR, 32'h0, 4'd0);
      add_vec(B_DOT, 32'h0, 4'd0);
      s = 32'h0;
      for (int k = 1; k <= 7; k++) begin
         s = (s << 4) | 32'(k);
         add_vec(dig(k), s, 4'(k));
      end
      add_vec(B_8, 32'h1234567, 4'd7);

      repeat (2) @(negedge clk);
      check("rst_req",  64'(bus.alu_req_o), 64'd0);
      check("rst_busy", 64'(bus.busy_o), 64'd0);
      check("rst_op",   64'(bus.alu_op_o), 64'(OP_NONE));
      check("rst_a",    64'(bus.alu_a_o), 64'd0);
      check("rst_b",    64'(bus.alu_b_o), 64'd0);
      check("rst_disp", 64'(bus.display_o), 64'd0);
      rst_n = 1'b1;

      foreach (vecs[i]) begin
         press(vecs[i].btn);
         check_disp($sformatf("vec%0d", i), mk(vecs[i].sig, vecs[i].expo));
      end

      // 3 + 4 = with a 3-cycle ALU delay, then operate on the result.
      press(B_CLEAR);
      press(B_3);
      press(B_ADD);
      check_disp("eq_acc", mk(32'h3));
      press(B_4);
      press(B_EQ);
      expect_req(OP_ADD, mk(32'h3), mk(32'h4));
      check("eq_busy", 64'(bus.busy_o), 64'd1);
      press(B_9);
      check_disp("eq_exec_disp", mk(32'h4));
      serve("eq", 3, mk(32'h7), 1'b0, mk(32'h7));
      press(B_ADD);
      check_disp("res_op_disp", mk(32'h7));
      press(B_2);
      check_disp("res_b_disp", mk(32'h2));
      press(B_EQ);
      expect_req(OP_ADD, mk(32'h7), mk(32'h2));
      serve("res", 0, mk(32'h9), 1'b0, mk(32'h9));

      // Chaining: 2 * 5 - 1 =
      press(B_CLEAR);
      press(B_2);
      press(B_MUL);
      press(B_5);
      press(B_SUB);
      expect_req(OP_MUL, mk(32'h2), mk(32'h5));
      serve("chain1", 2, mk(32'h10), 1'b0, mk(32'h10));
      press(B_1);
      check_disp("chain_b", mk(32'h1));
      press(B_EQ);
      expect_req(OP_SUB, mk(32'h10), mk(32'h1));
      serve("chain2", 1, mk(32'h9), 1'b0, mk(32'h9));

      // Operator replaced while waiting for B.
      press(B_CLEAR);
      press(B_6);
      press(B_ADD);
      press(B_MUL);
      press(B_2);
      press(B_EQ);
      expect_req(OP_MUL, mk(32'h6), mk(32'h2));
      serve("oprep", 0, mk(32'h12), 1'b0, mk(32'h12));

      // Clear while the request is outstanding.
      press(B_CLEAR);
      press(B_3);
      press(B_ADD);
      press(B_4);
      press(B_EQ);
      expect_req(OP_ADD, mk(32'h3), mk(32'h4));
      press(B_CLEAR);
      serve("clrx", 2, mk(32'h7), 1'b0, mk(32'h0));
      check("clrx_op", 64'(bus.alu_op_o), 64'(OP_NONE));
      check("clrx_a",  64'(bus.alu_a_o), 64'd0);
      press(B_5);
      check_disp("clrx_entry", mk(32'h5));
      press(B_EQ);
      check("clrx_eq_ignored", 64'(bus.alu_req_o), 64'd0);

      // Ack and clear in the same cycle.
      press(B_CLEAR);
      press(B_3);
      press(B_ADD);
      press(B_4);
      press(B_EQ);
      expect_req(OP_ADD, mk(32'h3), mk(32'h4));
      serve("clrsame", 2, mk(32'h7), 1'b1, mk(32'h0));
      press(B_5);
      check_disp("clrsame_entry", mk(32'h5));

      // Error result.
      press(B_CLEAR);
      press(B_8);
      press(B_DIV);
      press(B_0);
      press(B_EQ);
      expect_req(OP_DIV, mk(32'h8), mk(32'h0));
      serve("err", 1, mk(32'h0, 4'd0, 1'b1), 1'b0, mk(32'h0, 4'd0, 1'b1));
      press(B_5);
      check_disp("err_digit", mk(32'h0, 4'd0, 1'b1));
      press(B_ADD);
      check_disp("err_op", mk(32'h0, 4'd0, 1'b1));
      press(B_EQ);
      check("err_eq_req", 64'(bus.alu_req_o), 64'd0);
      press(B_CLEAR);
      check_disp("err_clear", mk(32'h0));
      check("err_clear_op", 64'(bus.alu_op_o), 64'(OP_NONE));
      press(B_5);
      check_disp("err_entry", mk(32'h5));

      // Asynchronous reset in the middle of a request.
      press(B_CLEAR);
      press(B_1);
      press(B_ADD);
      press(B_1);
      press(B_EQ);
      expect_req(OP_ADD, mk(32'h1), mk(32'h1));
      check("arst_req_pre", 64'(bus.alu_req_o), 64'd1);
      e = exp_q.pop_front();
      check("arst_op_pre", 64'(bus.alu_op_o), 64'(e.op));
      #2;
      rst_n = 1'b0;
      #1;
      check("arst_req",  64'(bus.alu_req_o), 64'd0);
      check("arst_busy", 64'(bus.busy_o), 64'd0);
      check("arst_disp", 64'(bus.display_o), 64'd0);
      @(negedge clk);
      rst_n = 1'b1;
      press(B_4);
      check_disp("arst_entry", mk(32'h4));

      check("sb_drain", 64'(exp_q.size()), 64'd0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end
endmodule
